mul_rs_multi: RTL
=================

Name: mul_rs_multi

Overview:
Multi-entry reservation station with an integrated pipelined multiplier for the out-of-order SPARC integer core. It accepts UMUL/SMUL/UMULcc/SMULcc issues with tag-or-value operands and snoops the CDB for pending operands. Ready entries are dispatched into a MUL_LAT-stage pipeline. Results are broadcast through a request/grant CDB handshake, with Y (high word) and ICC outputs. It generalises the single-entry MUL_RS to ENTRIES slots and adds arbitration, stall and flush behaviour.

Parameters:
ENTRIES, 4, number of RS slots (2..8)
DATA_W, 32, operand and result word width
TAG_W, 5, tag width; all-ones is INVALID_TAG (operand already valid)
MUL_LAT, 3, multiplier pipeline stages (>=1), including the output register
BASE_TAG, 8, entry i owns tag BASE_TAG+i; BASE_TAG+ENTRIES-1 < INVALID_TAG

Ports:
clk  in  1  clock, rising edge
rst  in  1  asynchronous, active-high reset
in_flush  in  1  synchronous squash of all entries and pipeline
in_rs_enable  in  1  issue request
in_operator_type  in  6  op3: 001010 UMUL, 011010 UMULcc, 001011 SMUL, 011011 SMULcc
in_val_1, in_val_2  in  DATA_W  operand values
in_tag_1, in_tag_2  in  TAG_W  operand tags; INVALID_TAG means the value is valid
in_CDB_broadcast  in  1  CDB valid
in_CDB_tag  in  TAG_W  CDB tag
in_CDB_val  in  DATA_W  CDB value
in_CDB_grant  in  1  arbiter grant for out_CDB_*
out_rs_full  out  1  all entries allocated
out_rs_tag  out  TAG_W  tag assigned to this cycle's accepted issue, else INVALID_TAG
out_CDB_req  out  1  result valid / broadcast request
out_CDB_tag  out  TAG_W  result tag
out_CDB_val  out  DATA_W  product[DATA_W-1:0]
out_Y_val  out  DATA_W  product[2*DATA_W-1:DATA_W]
out_ICC_valid  out  1  out_ICC_flags meaningful (cc op)
out_ICC_flags  out  4  {N,Z,V,C}

Behaviour:
- Reset (async): all entries free; pipeline and output register invalid; out_CDB_req=0; out_CDB_tag=INVALID_TAG; out_CDB_val=0; out_Y_val=0; out_ICC_valid=0; out_ICC_flags=0; out_rs_full=0; out_rs_tag=INVALID_TAG.
- Issue: accepted when in_rs_enable && !out_rs_full. Allocates the lowest free index i. out_rs_tag=BASE_TAG+i combinationally in the same cycle. The entry is written at the edge.
- out_rs_full reflects registered state only. A slot freed at an edge is allocatable from the next cycle. No same-cycle reuse.
- An issue while full is ignored, and out_rs_tag=INVALID_TAG.
- Operand capture: a tag equal to INVALID_TAG is taken as ready with in_val. Otherwise, if in_CDB_broadcast is high and in_CDB_tag matches in the issue cycle, the operand is ready with in_CDB_val (bypass). Otherwise the operand waits.
- Snoop: every waiting operand of every valid entry compares against the CDB each cycle. Both operands may capture from one broadcast.
- Dispatch: at most one entry per cycle — the lowest-index entry that is valid, not yet dispatched, has both operands ready, and the pipeline advances. Dispatch requires a ready state from the previous cycle; no same-cycle snoop-to-dispatch. The entry is marked dispatched but stays allocated.
- Pipeline advances when the output register is empty or in_CDB_grant=1 this cycle. Otherwise all stages hold and nothing dispatches.
- Latency: with both operands ready at issue edge E0, dispatch occurs at E1. out_CDB_req rises after edge E0+MUL_LAT+1 (E4 at default), assuming no stall.
- Arithmetic: 2*DATA_W-bit product. UMUL treats operands as unsigned; SMUL uses two's complement.
- ICC (cc ops only): N=product[DATA_W-1]; Z=(product[DATA_W-1:0]==0); V=0; C=0. For non-cc ops, out_ICC_valid=0 and the flags are 0.
- Retire: out_CDB_req stays high, with all outputs stable, until in_CDB_grant is sampled high. At that edge the owning entry is freed and the output register loads the next stage or goes invalid. Back-to-back results are possible with grant held high.
- Own broadcasts that loop back on in_CDB are snooped like any other tag.
- Flush (sync, dominates issue and grant): at the next edge, all entries are freed, pipeline and output invalidated, out_CDB_req=0 and out_rs_tag=INVALID_TAG.
- Reset mid-operation behaves identically, but asynchronously.

Test Plan:
1. UMUL val 2, val 3, both tags INVALID, grant=1 -> out_rs_tag=8; out_CDB_req after 4 edges with tag 8, val 6, Y 0, ICC_valid 0; entry 0 free after grant.
2. UMUL val_1=4, tag_2=3; two cycles later CDB tag 3 val 1 -> result 4 on tag 8. Issue with tag 2 while CDB broadcasts tag 2 val 7 in the same cycle -> bypass captured; second operand still waits.
3. SMULcc 0xFFFFFFFE x 3 -> val 0xFFFFFFFA, Y 0xFFFFFFFF, ICC 4'b1000. UMULcc 0x10000 x 0x10000 -> val 0, Y 1, ICC 4'b0100.
4. Fill 4 entries waiting on tag 2 -> out_rs_full=1; a 5th enable is ignored with out_rs_tag=31. Broadcast tag 2 -> results emerge in order 8, 9, 10, 11, one per cycle with grant=1.
5. Hold grant=0 with the pipeline full -> req and outputs stable, no further dispatch. Release grant -> results drain back-to-back with no loss or duplication.
6. Assert in_flush, and separately rst, with 3 entries in flight -> next cycle req=0, full=0, new issue gets tag 8; no stale result is ever broadcast.

Source files
------------

// File: rtl/mul_rs_multi.sv
// Multi-entry multiply reservation station: issue with tag/value operands, CDB snoop, lowest-ready dispatch.
// Latency issue-edge+MUL_LAT+1 to out_CDB_req; a pending result without in_CDB_grant stalls the pipe and dispatch.
module mul_rs_multi #(
  parameter int ENTRIES  = 4,
  parameter int DATA_W   = 32,
  parameter int TAG_W    = 5,
  parameter int MUL_LAT  = 3,
  parameter int BASE_TAG = 8
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              in_flush,
  input  logic              in_rs_enable,
  input  logic [5:0]        in_operator_type,
  input  logic [DATA_W-1:0] in_val_1,
  input  logic [DATA_W-1:0] in_val_2,
  input  logic [TAG_W-1:0]  in_tag_1,
  input  logic [TAG_W-1:0]  in_tag_2,
  input  logic              in_CDB_broadcast,
  input  logic [TAG_W-1:0]  in_CDB_tag,
  input  logic [DATA_W-1:0] in_CDB_val,
  input  logic              in_CDB_grant,
  output logic              out_rs_full,
  output logic [TAG_W-1:0]  out_rs_tag,
  output logic              out_CDB_req,
  output logic [TAG_W-1:0]  out_CDB_tag,
  output logic [DATA_W-1:0] out_CDB_val,
  output logic [DATA_W-1:0] out_Y_val,
  output logic              out_ICC_valid,
  output logic [3:0]        out_ICC_flags
);

  localparam int IDX_W = $clog2(ENTRIES);
  localparam logic [TAG_W-1:0] INVALID_TAG = '1;
  localparam logic [TAG_W-1:0] BASE_T = TAG_W'(BASE_TAG);

  logic [ENTRIES-1:0] r_vld, r_disp, r_rdy1, r_rdy2, r_sgn, r_cc;
  logic [DATA_W-1:0]  r_val1 [ENTRIES];
  logic [DATA_W-1:0]  r_val2 [ENTRIES];
  logic [TAG_W-1:0]   r_tag1 [ENTRIES];
  logic [TAG_W-1:0]   r_tag2 [ENTRIES];

  logic               r_op_vld, r_op_sgn, r_op_cc;
  logic [DATA_W-1:0]  r_op_a, r_op_b;
  logic [TAG_W-1:0]   r_op_tag;
  logic [MUL_LAT-1:0] r_pv, r_picc;
  logic [TAG_W-1:0]   r_ptag  [MUL_LAT];
  logic [2*DATA_W-1:0] r_pprod [MUL_LAT];
  logic [3:0]         r_pflg  [MUL_LAT];

  logic               w_full, w_issue, w_alloc_found, w_dsp_found;
  logic               w_adv, w_dispatch, w_retire, w_op_live;
  logic [IDX_W-1:0]   w_alloc_idx, w_dsp_idx, w_ret_idx;
  logic               w_rdy1_in, w_rdy2_in, w_sgn_in, w_cc_in;
  logic [DATA_W-1:0]  w_val1_in, w_val2_in;
  logic [2*DATA_W-1:0] w_a_ext, w_b_ext, w_prod;
  logic [3:0]         w_flg;

  // Descending scan so the lowest qualifying index is the one left standing.
  always_comb begin
    w_alloc_found = 1'b0;
    w_alloc_idx   = '0;
    w_dsp_found   = 1'b0;
    w_dsp_idx     = '0;
    for (int i = ENTRIES - 1; i >= 0; i--) begin
      if (!r_vld[i]) begin
        w_alloc_found = 1'b1;
        w_alloc_idx   = IDX_W'(i);
      end
      if (r_vld[i] && !r_disp[i] && r_rdy1[i] && r_rdy2[i]) begin
        w_dsp_found = 1'b1;
        w_dsp_idx   = IDX_W'(i);
      end
    end
  end

  assign w_full      = !w_alloc_found;
  assign w_issue     = in_rs_enable && !w_full && !in_flush;
  assign out_rs_full = w_full;
  assign out_rs_tag  = w_issue ? (BASE_T + TAG_W'(w_alloc_idx)) : INVALID_TAG;

  assign w_adv      = !r_pv[MUL_LAT-1] || in_CDB_grant;
  assign w_dispatch = w_dsp_found && w_adv && !in_flush;
  assign w_retire   = r_pv[MUL_LAT-1] && in_CDB_grant && !in_flush;
  assign w_ret_idx  = IDX_W'(r_ptag[MUL_LAT-1] - BASE_T);

  assign w_sgn_in  = (in_operator_type == 6'b001011) || (in_operator_type == 6'b011011);
  assign w_cc_in   = (in_operator_type == 6'b011010) || (in_operator_type == 6'b011011);
  assign w_rdy1_in = (in_tag_1 == INVALID_TAG) || (in_CDB_broadcast && in_CDB_tag == in_tag_1);
  assign w_rdy2_in = (in_tag_2 == INVALID_TAG) || (in_CDB_broadcast && in_CDB_tag == in_tag_2);
  assign w_val1_in = (in_tag_1 == INVALID_TAG) ? in_val_1 : in_CDB_val;
  assign w_val2_in = (in_tag_2 == INVALID_TAG) ? in_val_2 : in_CDB_val;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_vld  <= '0;
      r_disp <= '0;
      r_rdy1 <= '0;
      r_rdy2 <= '0;
      r_sgn  <= '0;
      r_cc   <= '0;
      for (int i = 0; i < ENTRIES; i++) begin
        r_val1[i] <= '0;
        r_val2[i] <= '0;
        r_tag1[i] <= INVALID_TAG;
        r_tag2[i] <= INVALID_TAG;
      end
    end else if (in_flush) begin
      r_vld  <= '0;
      r_disp <= '0;
      r_rdy1 <= '0;
      r_rdy2 <= '0;
    end else begin
      for (int i = 0; i < ENTRIES; i++) begin
        if (in_CDB_broadcast && r_vld[i]) begin
          if (!r_rdy1[i] && r_tag1[i] == in_CDB_tag) begin
            r_rdy1[i] <= 1'b1;
            r_val1[i] <= in_CDB_val;
          end
          if (!r_rdy2[i] && r_tag2[i] == in_CDB_tag) begin
            r_rdy2[i] <= 1'b1;
            r_val2[i] <= in_CDB_val;
          end
        end
        if (w_dispatch && w_dsp_idx == IDX_W'(i)) r_disp[i] <= 1'b1;
        if (w_retire && w_ret_idx == IDX_W'(i)) begin
          r_vld[i]  <= 1'b0;
          r_disp[i] <= 1'b0;
        end
        if (w_issue && w_alloc_idx == IDX_W'(i)) begin
          r_vld[i]  <= 1'b1;
          r_disp[i] <= 1'b0;
          r_rdy1[i] <= w_rdy1_in;
          r_rdy2[i] <= w_rdy2_in;
          r_val1[i] <= w_val1_in;
          r_val2[i] <= w_val2_in;
          r_tag1[i] <= in_tag_1;
          r_tag2[i] <= in_tag_2;
          r_sgn[i]  <= w_sgn_in;
          r_cc[i]   <= w_cc_in;
        end
      end
    end
  end

  assign w_a_ext   = {{DATA_W{r_op_sgn & r_op_a[DATA_W-1]}}, r_op_a};
  assign w_b_ext   = {{DATA_W{r_op_sgn & r_op_b[DATA_W-1]}}, r_op_b};
  assign w_prod    = w_a_ext * w_b_ext;
  assign w_flg     = {w_prod[DATA_W-1], ~|w_prod[DATA_W-1:0], 2'b00};
  assign w_op_live = r_op_vld && !in_flush;

  // Invalid slots carry INVALID_TAG and zero data so the output register is clean when idle.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_op_vld <= 1'b0;
      r_op_sgn <= 1'b0;
      r_op_cc  <= 1'b0;
      r_op_a   <= '0;
      r_op_b   <= '0;
      r_op_tag <= INVALID_TAG;
      r_pv     <= '0;
      r_picc   <= '0;
      for (int k = 0; k < MUL_LAT; k++) begin
        r_ptag[k]  <= INVALID_TAG;
        r_pprod[k] <= '0;
        r_pflg[k]  <= '0;
      end
    end else if (in_flush || w_adv) begin
      r_op_vld   <= w_dispatch;
      r_op_sgn   <= r_sgn[w_dsp_idx];
      r_op_cc    <= r_cc[w_dsp_idx];
      r_op_a     <= r_val1[w_dsp_idx];
      r_op_b     <= r_val2[w_dsp_idx];
      r_op_tag   <= BASE_T + TAG_W'(w_dsp_idx);
      r_pv[0]    <= w_op_live;
      r_picc[0]  <= w_op_live && r_op_cc;
      r_ptag[0]  <= w_op_live ? r_op_tag : INVALID_TAG;
      r_pprod[0] <= w_op_live ? w_prod : '0;
      r_pflg[0]  <= (w_op_live && r_op_cc) ? w_flg : 4'b0000;
      for (int k = 1; k < MUL_LAT; k++) begin
        r_pv[k]    <= r_pv[k-1] && !in_flush;
        r_picc[k]  <= r_picc[k-1] && !in_flush;
        r_ptag[k]  <= in_flush ? INVALID_TAG : r_ptag[k-1];
        r_pprod[k] <= in_flush ? '0 : r_pprod[k-1];
        r_pflg[k]  <= in_flush ? 4'b0000 : r_pflg[k-1];
      end
    end
  end

  assign out_CDB_req   = r_pv[MUL_LAT-1];
  assign out_CDB_tag   = r_ptag[MUL_LAT-1];
  assign out_CDB_val   = r_pprod[MUL_LAT-1][DATA_W-1:0];
  assign out_Y_val     = r_pprod[MUL_LAT-1][2*DATA_W-1:DATA_W];
  assign out_ICC_valid = r_picc[MUL_LAT-1];
  assign out_ICC_flags = r_pflg[MUL_LAT-1];

endmodule
